// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: bridges pipeline loads/stores onto a word-wide
// memory bus, with read-modify-write for byte/halfword stores and a read timeout.
module dmem_port_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [31:0] pipe_address,
  input  logic [31:0] pipe_writedata,
  input  logic        pipe_memread,
  input  logic        pipe_memwrite,
  input  logic [1:0]  pipe_maskmode,
  input  logic        pipe_sext,
  output logic        pipe_done,
  output logic        pipe_error,
  output logic [31:0] pipe_readdata,
  output logic        mem_request_valid,
  input  logic        mem_request_ready,
  output logic [31:0] mem_request_address,
  output logic [31:0] mem_request_writedata,
  output logic [1:0]  mem_request_operation,
  input  logic        mem_response_valid,
  input  logic [31:0] mem_response_data
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RMW_REQ,
    RMW_WAIT,
    WR_REQ,
    FIN
  } state_e;

  state_e         state_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    reqData_q;
  logic [31:0]    rdata_q;
  logic [1:0]     mask_q;
  logic           sext_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;

  logic [4:0]     laneShift;
  logic [31:0]    laneData;
  logic [31:0]    loadValue;
  logic [31:0]    laneMask;
  logic [31:0]    mergeValue;
  logic           acceptError;
  logic           waitTimeout;
  logic [CW-1:0]  cntInc;

  // Lane extraction for loads and lane merge for sub-word stores share one shift.
  always_comb begin
    laneShift = {addr_q[1:0], 3'b000};
    laneData  = mem_response_data >> laneShift;
    case (mask_q)
      2'd0:    loadValue = {{24{sext_q & laneData[7]}}, laneData[7:0]};
      2'd1:    loadValue = {{16{sext_q & laneData[15]}}, laneData[15:0]};
      default: loadValue = laneData;
    endcase
    laneMask   = ((mask_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << laneShift;
    mergeValue = (mem_response_data & ~laneMask) | ((wdata_q << laneShift) & laneMask);
  end

  assign acceptError = (pipe_memread == pipe_memwrite) ||
                       (pipe_maskmode == 2'd3) ||
                       ((pipe_maskmode == 2'd1) && pipe_address[0]) ||
                       ((pipe_maskmode == 2'd2) && (pipe_address[1:0] != 2'b00));

  assign waitTimeout = (cnt_q >= CNT_LAST);
  assign cntInc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  assign pipe_ready            = (state_q == IDLE);
  assign pipe_done             = (state_q == FIN);
  assign pipe_error            = (state_q == FIN) && err_q;
  assign pipe_readdata         = rdata_q;
  assign mem_request_valid     = state_q inside {RD_REQ, RMW_REQ, WR_REQ};
  assign mem_request_address   = {addr_q[31:2], 2'b00};
  assign mem_request_writedata = reqData_q;
  assign mem_request_operation = (state_q == WR_REQ) ? 2'd1 : 2'd0;

  // Response data is only looked at in the request/wait states, so late responses fall on the floor.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      reqData_q <= '0;
      rdata_q   <= '0;
      mask_q    <= '0;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pipe_valid) begin
            addr_q  <= pipe_address;
            wdata_q <= pipe_writedata;
            mask_q  <= pipe_maskmode;
            sext_q  <= pipe_sext;
            if (acceptError) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= FIN;
            end else begin
              err_q <= 1'b0;
              if (pipe_memread) begin
                state_q <= RD_REQ;
              end else if (pipe_maskmode == 2'd2) begin
                reqData_q <= pipe_writedata;
                state_q   <= WR_REQ;
              end else begin
                state_q <= RMW_REQ;
              end
            end
          end
        end
        RD_REQ: begin
          if (mem_request_ready) begin
            if (mem_response_valid) begin
              rdata_q <= loadValue;
              state_q <= FIN;
            end else begin
              cnt_q   <= '0;
              state_q <= RD_WAIT;
            end
          end
        end
        RMW_REQ: begin
          if (mem_request_ready) begin
            if (mem_response_valid) begin
              reqData_q <= mergeValue;
              state_q   <= WR_REQ;
            end else begin
              cnt_q   <= '0;
              state_q <= RMW_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (mem_response_valid) begin
            rdata_q <= loadValue;
            state_q <= FIN;
          end else begin
            cnt_q <= cntInc;
            if (waitTimeout) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= FIN;
            end
          end
        end
        RMW_WAIT: begin
          if (mem_response_valid) begin
            reqData_q <= mergeValue;
            state_q   <= WR_REQ;
          end else begin
            cnt_q <= cntInc;
            if (waitTimeout) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= FIN;
            end
          end
        end
        WR_REQ: begin
          if (mem_request_ready) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl: table-driven accesses against a small
// memory responder, plus hand sequences for backpressure, reset mid-RMW and timeout.
module tb_dmem_port_ctrl;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic        pipe_ready;
  logic [31:0] pipe_address;
  logic [31:0] pipe_writedata;
  logic        pipe_memread;
  logic        pipe_memwrite;
  logic [1:0]  pipe_maskmode;
  logic        pipe_sext;
  logic        pipe_done;
  logic        pipe_error;
  logic [31:0] pipe_readdata;
  logic        mem_request_valid;
  logic        mem_request_ready;
  logic [31:0] mem_request_address;
  logic [31:0] mem_request_writedata;
  logic [1:0]  mem_request_operation;
  logic        mem_response_valid;
  logic [31:0] mem_response_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic        sext;
    logic [31:0] memWord;
    logic [31:0] expData;
    logic        expErr;
    logic [31:0] expWData;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  exp_t        expQ[$];
  req_t        reqLog[$];
  exp_t        sbEntry;
  vec_t        vecs[17];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          doneSeen = 0;
  int          validCycles = 0;
  int          respDelay = 0;
  logic        respComb = 1'b1;
  logic        memReady = 1'b1;
  logic        latResp = 1'b0;
  logic [31:0] memWord = 32'h0;
  logic [31:0] lastRead = 32'h0;

  dmem_port_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .pipe_valid            (pipe_valid),
    .pipe_ready            (pipe_ready),
    .pipe_address          (pipe_address),
    .pipe_writedata        (pipe_writedata),
    .pipe_memread          (pipe_memread),
    .pipe_memwrite         (pipe_memwrite),
    .pipe_maskmode         (pipe_maskmode),
    .pipe_sext             (pipe_sext),
    .pipe_done             (pipe_done),
    .pipe_error            (pipe_error),
    .pipe_readdata         (pipe_readdata),
    .mem_request_valid     (mem_request_valid),
    .mem_request_ready     (mem_request_ready),
    .mem_request_address   (mem_request_address),
    .mem_request_writedata (mem_request_writedata),
    .mem_request_operation (mem_request_operation),
    .mem_response_valid    (mem_response_valid),
    .mem_response_data     (mem_response_data)
  );

  always #5 clock = ~clock;

  // Memory model: same-cycle response when respComb, otherwise a pulse respDelay cycles into the wait.
  assign mem_request_ready  = memReady;
  assign mem_response_data  = memWord;
  assign mem_response_valid = respComb ? (mem_request_valid && mem_request_ready && (mem_request_operation == 2'd0))
                                       : latResp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #4;
      if (reset && mem_request_valid && mem_request_ready && (mem_request_operation == 2'd0) && !respComb) begin
        @(posedge clock);
        repeat (respDelay) @(negedge clock);
        latResp = 1'b1;
        @(negedge clock);
        latResp = 1'b0;
      end
    end
  end

  // Log every request handshake just before the edge that takes it.
  always @(negedge clock) begin
    #4;
    if (reset && mem_request_valid) begin
      validCycles++;
      if (mem_request_ready)
        reqLog.push_back('{mem_request_operation, mem_request_address, mem_request_writedata});
    end
  end

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clock) begin
    #1;
    if (reset && pipe_done) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected done: got done=1 error=%0b data=0x%08h, expected no done", pipe_error, pipe_readdata);
      end else begin
        sbEntry = expQ.pop_front();
        checkOutput("readdata", pipe_readdata, sbEntry.data);
        checkOutput("error", {31'b0, pipe_error}, {31'b0, sbEntry.err});
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int delay, input int stall);
    int          cycles;
    int          lat;
    int          nReq;
    int          startDone;
    int          startValid;
    logic        isRmw;
    logic        timedOut;
    logic [31:0] wordAddr;
    exp_t        e;
    isRmw    = !v.expErr && !v.rd && (v.mask != 2'd2);
    timedOut = !v.expErr && (v.rd || isRmw) && (delay > TO);
    wordAddr = v.addr & 32'hFFFF_FFFC;
    e.err    = v.expErr || timedOut;
    e.data   = e.err ? 32'h0 : (v.rd ? v.expData : lastRead);
    lastRead = e.data;
    if (v.expErr)       lat = 1;
    else if (timedOut)  lat = 2 + TO;
    else if (v.rd)      lat = 2 + delay;
    else if (isRmw)     lat = 3 + delay;
    else                lat = 2 + stall;
    if (v.expErr)                nReq = 0;
    else if (timedOut || v.rd)   nReq = 1;
    else if (isRmw)              nReq = 2;
    else                         nReq = 1;

    @(negedge clock);
    cycles = 0;
    while (!pipe_ready && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    if (!pipe_ready) checkOutput("ready before accept", {31'b0, pipe_ready}, 32'd1);

    respDelay      = delay;
    respComb       = (delay == 0);
    memWord        = v.memWord;
    memReady       = (stall == 0);
    reqLog.delete();
    startDone      = doneSeen;
    startValid     = validCycles;
    pipe_valid     = 1'b1;
    pipe_address   = v.addr;
    pipe_writedata = v.wdata;
    pipe_memread   = v.rd;
    pipe_memwrite  = v.wr;
    pipe_maskmode  = v.mask;
    pipe_sext      = v.sext;
    expQ.push_back(e);

    cycles = 0;
    while (doneSeen == startDone && cycles < 60) begin
      @(negedge clock);
      if (cycles == 0) pipe_valid = 1'b0;
      #2;
      cycles++;
      if (cycles <= stall) begin
        checkOutput("stall valid", {31'b0, mem_request_valid}, 32'd1);
        checkOutput("stall address", mem_request_address, wordAddr);
        checkOutput("stall writedata", mem_request_writedata, v.wdata);
        checkOutput("stall operation", {30'b0, mem_request_operation}, 32'd1);
      end else if (cycles == stall + 1) begin
        memReady = 1'b1;
      end
    end
    if (doneSeen == startDone) checkOutput("done within bound", {31'b0, pipe_done}, 32'd1);
    checkOutput("latency", 32'(cycles), 32'(lat));
    checkOutput("request count", 32'(reqLog.size()), 32'(nReq));
    if (v.expErr) checkOutput("valid cycles on error", 32'(validCycles - startValid), 32'd0);
    if (reqLog.size() == nReq && nReq > 0) begin
      checkOutput("req0 address", reqLog[0].addr, wordAddr);
      checkOutput("req0 operation", {30'b0, reqLog[0].op}, (v.rd || isRmw || timedOut) ? 32'd0 : 32'd1);
      if (!v.rd && !isRmw && !timedOut) checkOutput("write data", reqLog[0].data, v.expWData);
      if (nReq == 2) begin
        checkOutput("req1 address", reqLog[1].addr, wordAddr);
        checkOutput("req1 operation", {30'b0, reqLog[1].op}, 32'd1);
        checkOutput("rmw write data", reqLog[1].data, v.expWData);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startDone;

    //          addr          wdata         rd    wr    mask  sext  memWord       expData       err   expWData
    vecs[0]  = '{32'h103,     32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 32'h0};
    vecs[1]  = '{32'h101,     32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 32'h80FF1234, 32'h00000012, 1'b0, 32'h0};
    vecs[2]  = '{32'h102,     32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 32'h80FF1234, 32'hFFFF80FF, 1'b0, 32'h0};
    vecs[3]  = '{32'h100,     32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 32'h80FF1234, 32'h00001234, 1'b0, 32'h0};
    vecs[4]  = '{32'h200,     32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[5]  = '{32'h102,     32'h0000ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 32'h11223344, 32'h0,        1'b0, 32'hABCD3344};
    vecs[6]  = '{32'h201,     32'h1234565A, 1'b0, 1'b1, 2'd0, 1'b0, 32'h11223344, 32'h0,        1'b0, 32'h11225A44};
    vecs[7]  = '{32'h40,      32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[8]  = '{32'h101,     32'h0,        1'b1, 1'b0, 2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{32'h103,     32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{32'h100,     32'h0,        1'b1, 1'b0, 2'd3, 1'b0, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{32'h100,     32'h0,        1'b1, 1'b1, 2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{32'h100,     32'h0,        1'b0, 1'b0, 2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[13] = '{32'h0,       32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 32'h0000007F, 32'h0000007F, 1'b0, 32'h0};
    vecs[14] = '{32'h3,       32'h000000FF, 1'b0, 1'b1, 2'd0, 1'b0, 32'h00000000, 32'h0,        1'b0, 32'hFF000000};
    vecs[15] = '{32'h0,       32'h0,        1'b1, 1'b0, 2'd1, 1'b1, 32'h12348001, 32'hFFFF8001, 1'b0, 32'h0};
    vecs[16] = '{32'h2,       32'h0,        1'b1, 1'b0, 2'd1, 1'b0, 32'hF00D0000, 32'h0000F00D, 1'b0, 32'h0};

    reset          = 1'b0;
    pipe_valid     = 1'b0;
    pipe_address   = '0;
    pipe_writedata = '0;
    pipe_memread   = 1'b0;
    pipe_memwrite  = 1'b0;
    pipe_maskmode  = '0;
    pipe_sext      = 1'b0;

    @(negedge clock);
    #1;
    checkOutput("reset done", {31'b0, pipe_done}, 32'd0);
    checkOutput("reset error", {31'b0, pipe_error}, 32'd0);
    checkOutput("reset req valid", {31'b0, mem_request_valid}, 32'd0);
    checkOutput("reset readdata", pipe_readdata, 32'h0);
    checkOutput("reset req address", mem_request_address, 32'h0);
    checkOutput("reset req writedata", mem_request_writedata, 32'h0);
    checkOutput("reset req operation", {30'b0, mem_request_operation}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #2;
    checkOutput("ready after reset", {31'b0, pipe_ready}, 32'd1);

    for (int i = 0; i < 17; i++)
      applyStimulus(vecs[i], (i % 2 == 1) ? (i % 3) + 1 : 0, 0);

    // Word store held off by five cycles of backpressure, longer than the read timeout.
    applyStimulus('{32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF}, 0, 5);

    // Byte store interrupted by reset while waiting for its read.
    @(negedge clock);
    respComb       = 1'b0;
    respDelay      = 8;
    memReady       = 1'b1;
    memWord        = 32'h11223344;
    reqLog.delete();
    startDone      = doneSeen;
    pipe_valid     = 1'b1;
    pipe_address   = 32'h101;
    pipe_writedata = 32'h00000077;
    pipe_memread   = 1'b0;
    pipe_memwrite  = 1'b1;
    pipe_maskmode  = 2'd0;
    pipe_sext      = 1'b0;
    @(negedge clock);
    pipe_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("mid-rmw reset ready", {31'b0, pipe_ready}, 32'd1);
    checkOutput("mid-rmw reset done", {31'b0, pipe_done}, 32'd0);
    checkOutput("mid-rmw reset error", {31'b0, pipe_error}, 32'd0);
    checkOutput("mid-rmw reset req valid", {31'b0, mem_request_valid}, 32'd0);
    checkOutput("mid-rmw reset readdata", pipe_readdata, 32'h0);
    checkOutput("mid-rmw reset req address", mem_request_address, 32'h0);
    checkOutput("mid-rmw reset req writedata", mem_request_writedata, 32'h0);
    checkOutput("mid-rmw reset req operation", {30'b0, mem_request_operation}, 32'd0);
    reqLog.delete();
    repeat (2) @(negedge clock);
    reset    = 1'b1;
    lastRead = 32'h0;
    repeat (12) @(negedge clock);
    #2;
    checkOutput("no done after reset", 32'(doneSeen), 32'(startDone));
    checkOutput("no request after reset", 32'(reqLog.size()), 32'd0);
    checkOutput("ready after mid-rmw reset", {31'b0, pipe_ready}, 32'd1);

    // Load whose response arrives well after the timeout has fired.
    vecs[0] = '{32'h300, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h55AA55AA, 32'h55AA55AA, 1'b0, 32'h0};
    applyStimulus(vecs[0], 7, 0);
    startDone = doneSeen;
    repeat (10) @(negedge clock);
    #2;
    checkOutput("late response ignored", 32'(doneSeen), 32'(startDone));
    checkOutput("ready after timeout", {31'b0, pipe_ready}, 32'd1);
    checkOutput("readdata after timeout", pipe_readdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
DMEM_PORT_CTRL -- requirements
Module: dmem_port_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for a read response before abort.
REQ-002 SHALL have ports (all synchronous to clock):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- pipe_valid  in  1  pipeline presents an access.
- pipe_ready  out  1  block idle, can accept.
- pipe_address  in  32  byte address.
- pipe_writedata  in  32  store data, right-aligned.
- pipe_memread  in  1  load.
- pipe_memwrite  in  1  store.
- pipe_maskmode  in  2  0 byte, 1 half, 2 word; 3 illegal.
- pipe_sext  in  1  sign-extend loads.
- pipe_done  out  1  one-cycle completion pulse.
- pipe_error  out  1  qualifies pipe_done.
- pipe_readdata  out  32  load result, valid with pipe_done.
- mem_request_valid  out  1
- mem_request_ready  in  1
- mem_request_address  out  32  always word-aligned.
- mem_request_writedata  out  32
- mem_request_operation  out  2  0 read, 1 write.
- mem_response_valid  in  1
- mem_response_data  in  32

Function
REQ-003 SHALL implement states IDLE, RD_REQ, RD_WAIT, RMW_REQ, RMW_WAIT, WR_REQ, FIN.
REQ-004 SHALL drive pipe_ready=1 only in IDLE; accept when pipe_valid&&pipe_ready, latching address, writedata, maskmode, sext, and op.
REQ-005 SHALL flag an error and go IDLE->FIN with no memory request when: memread==memwrite, maskmode==3, half with address[0]=1, or word with address[1:0]!=0.
REQ-006 SHALL route legal accepts: load->RD_REQ; word store->WR_REQ; byte/half store->RMW_REQ.
REQ-007 SHALL drive mem_request_valid=1 only in RD_REQ, RMW_REQ, and WR_REQ, with address = latched address & 0xFFFFFFFC; operation 0 in RD_REQ/RMW_REQ, 1 in WR_REQ.
REQ-008 SHALL hold the request fields stable while valid=1 and ready=0.
REQ-009 In RD_REQ/RMW_REQ, on ready: SHALL capture the response in the same cycle if mem_response_valid=1 (combinational memory), else go to the *_WAIT state.
REQ-010 In *_WAIT, SHALL capture the first cycle with mem_response_valid=1, and SHALL ignore mem_response_valid in every other state.
REQ-011 Load capture: lane = data >> (8*address[1:0]); mask to 8/16/32 bits; if sext, replicate bit 7/15 into the upper bits; then go to FIN.
REQ-012 RMW capture: replace the addressed byte/halfword lane of the read word with the low bits of writedata, keep other lanes, then go to WR_REQ.
REQ-013 WR_REQ: on ready, SHALL go to FIN; no write response expected.
REQ-014 FIN: SHALL assert pipe_done=1 for exactly one cycle with pipe_readdata/pipe_error, then go to IDLE.
REQ-015 pipe_readdata SHALL hold its last load value until the next load completes; after a store it is unchanged; after an error it is 0.
REQ-016 SHALL count cycles spent in *_WAIT; on reaching TIMEOUT_CYCLES, go to FIN with pipe_error=1, readdata 0, and no write issued.
REQ-017 The counter SHALL clear on entry to each *_WAIT state and saturate, never wrap.
REQ-018 Stalled request phases (ready=0) SHALL NOT time out.
REQ-019 A late response arriving after timeout SHALL have no effect.

Reset
REQ-020 On reset=0, SHALL asynchronously enter IDLE.
REQ-021 During reset: pipe_ready=1 after release; pipe_done, pipe_error, and mem_request_valid=0; pipe_readdata, mem_request_address, mem_request_writedata, and operation=0; counter=0.
REQ-022 Reset mid-access SHALL abandon it silently: no done pulse, no write.

Verification
REQ-023 Combinational-memory load: lb sext at 0x103, mem word 0x80FF1234, ready and response in the same cycle -> one request at 0x100, op 0; done two cycles after accept; readdata 0xFFFFFF80.
REQ-024 Half store: sh 0xABCD to 0x102 over word 0x11223344 -> read at 0x100, then write 0xABCD3344 at 0x100 op 1, then done, error 0.
REQ-025 Misaligned: lw 0x101 -> no mem_request_valid; done with error=1, readdata 0, next cycle.
REQ-026 Backpressure: ready low 5 cycles on sw 0xDEADBEEF to 0x40 -> request fields stable all 5 cycles; single accepted write; no timeout.
REQ-027 Timeout: TIMEOUT_CYCLES=4, load, no response -> done+error exactly 4 cycles after entering RD_WAIT; a later response is ignored and pipe_ready=1.
REQ-028 Reset mid-RMW: reset low while in RMW_WAIT -> outputs at reset values immediately; no write and no done pulse after release.
